// File: rtl/wb_axis_fifo.sv
// wb_axis_fifo: buffering stage between the Wishbone slave port and the FIR
// AXI-Stream ports.
//   - Wishbone writes to 0x80 fill the X FIFO, which drains into ss_* and
//     generates ss_tlast from a programmable frame length.
//   - FIR results arriving on sm_* fill the Y FIFO, which the CPU drains with
//     Wishbone reads of 0x84.
//   - 0x88 is a status word and 0x8C the frame-length register.
// Register map (address bits [7:0] only):
//   0x80 W  push X sample
//   0x84 R  pop Y sample (stalls while Y is empty)
//   0x88 R  status: b0 x_empty, b1 x_full, b2 y_empty, b3 y_full,
//           b4 y_last_seen, b5 timeout_seen, [11:8] x_level, [19:16] y_level.
//           Reading it clears b4/b5.
//   0x8C RW frame length. Writing it also restarts the beat counter.
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_*                     Wishbone slave (wbs_sel_i ignored, full words)
//   ss_tvalid/tready/tdata/tlast  AXI-Stream master towards the FIR (X data)
//   sm_tvalid/tready/tdata/tlast  AXI-Stream slave from the FIR (Y data)
// Optional feature macro: WB_STALL_TIMEOUT_EN. When it is defined, a request
// that stalls for TIMEOUT cycles is force-acknowledged. A forced write is
// dropped. A forced read returns 32'hDEAD_BEEF and pops nothing. The event
// sets the timeout_seen flag.
module wb_axis_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH_LOG2  = 3,
    parameter int LEN_W       = 10,
    parameter int TIMEOUT     = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   ss_tvalid,
    input  logic                   ss_tready,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   sm_tvalid,
    output logic                   sm_tready,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] EMPTY_LVL = LVL_W'(0);
    localparam logic [7:0] ADR_X    = 8'h80;
    localparam logic [7:0] ADR_Y    = 8'h84;
    localparam logic [7:0] ADR_STAT = 8'h88;
    localparam logic [7:0] ADR_LEN  = 8'h8C;
    localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(64);

    // Wishbone request / response
    logic        req_s;
    logic [7:0]  adr_s;
    logic        accept_s;
    logic        force_s;
    logic        x_push_s;
    logic        y_pop_s;
    logic        len_wr_s;
    logic        stat_rd_s;
    logic [31:0] rdata_s;
    logic [31:0] status_s;
    logic        to_bit_s;
    logic        ack_d, ack_q;
    logic [31:0] dat_d, dat_q;

    // X FIFO
    logic [pDATA_WIDTH-1:0] x_mem_q [DEPTH];
    logic [PTR_W-1:0]       x_wr_d, x_wr_q, x_rd_d, x_rd_q;
    logic [LVL_W-1:0]       x_level_d, x_level_q;
    logic                   x_empty_s, x_full_s, x_pop_s;

    // Y FIFO
    logic [pDATA_WIDTH-1:0] y_mem_q [DEPTH];
    logic [PTR_W-1:0]       y_wr_d, y_wr_q, y_rd_d, y_rd_q;
    logic [LVL_W-1:0]       y_level_d, y_level_q;
    logic                   y_empty_s, y_full_s, y_push_s;
    logic                   y_last_d, y_last_q;

    // Frame length and beat counter
    logic [LEN_W-1:0] len_d, len_q;
    logic [LEN_W-1:0] len_eff_s;
    logic [LEN_W-1:0] cnt_d, cnt_q;
    logic [LEN_W:0]   cnt_inc_s;
    logic             last_hit_s;

    // Inputs that carry no information for this block
    logic unused_inputs_s;
    assign unused_inputs_s = ^{wbs_sel_i, wbs_adr_i[31:8]};

    assign req_s     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign adr_s     = wbs_adr_i[7:0];
    assign x_empty_s = (x_level_q == EMPTY_LVL);
    assign x_full_s  = (x_level_q == FULL_LVL);
    assign y_empty_s = (y_level_q == EMPTY_LVL);
    assign y_full_s  = (y_level_q == FULL_LVL);

    assign ss_tvalid = ~x_empty_s;
    assign ss_tdata  = x_mem_q[x_rd_q];
    assign ss_tlast  = ss_tvalid & last_hit_s;
    assign x_pop_s   = ss_tvalid & ss_tready;
    assign sm_tready = ~y_full_s;
    assign y_push_s  = sm_tvalid & sm_tready;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // A zero length would never raise tlast, so it is treated as one.
    assign len_eff_s  = (len_q == LEN_W'(0)) ? LEN_W'(1) : len_q;
    assign cnt_inc_s  = {1'b0, cnt_q} + (LEN_W + 1)'(1);
    assign last_hit_s = (cnt_inc_s >= {1'b0, len_eff_s});

    assign status_s = {12'h000, 4'(y_level_q), 4'h0, 4'(x_level_q), 2'b00,
                       to_bit_s, y_last_q, y_full_s, y_empty_s, x_full_s, x_empty_s};

    // Address decode: acceptance, FIFO side effects and read data.
    always_comb begin
        accept_s  = 1'b0;
        x_push_s  = 1'b0;
        y_pop_s   = 1'b0;
        len_wr_s  = 1'b0;
        stat_rd_s = 1'b0;
        rdata_s   = 32'h0000_0000;
        if (req_s) begin
            case (adr_s)
                ADR_X: begin
                    if (wbs_we_i) begin
                        if (!x_full_s) begin
                            accept_s = 1'b1;
                            x_push_s = 1'b1;
                        end else begin
                            accept_s = 1'b0;
                        end
                    end else begin
                        accept_s = 1'b1;
                    end
                end
                ADR_Y: begin
                    if (!wbs_we_i) begin
                        if (!y_empty_s) begin
                            accept_s = 1'b1;
                            y_pop_s  = 1'b1;
                            rdata_s  = 32'(y_mem_q[y_rd_q]);
                        end else begin
                            accept_s = 1'b0;
                        end
                    end else begin
                        accept_s = 1'b1;
                    end
                end
                ADR_STAT: begin
                    accept_s = 1'b1;
                    if (!wbs_we_i) begin
                        stat_rd_s = 1'b1;
                        rdata_s   = status_s;
                    end else begin
                        stat_rd_s = 1'b0;
                    end
                end
                ADR_LEN: begin
                    accept_s = 1'b1;
                    if (wbs_we_i) begin
                        len_wr_s = 1'b1;
                    end else begin
                        rdata_s = 32'(len_q);
                    end
                end
                default: begin
                    accept_s = 1'b1;
                end
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

`ifdef WB_STALL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_d, stall_q;
    logic               to_seen_d, to_seen_q;

    // Stall counter and forced-ack decision for requests that never get accepted.
    always_comb begin
        force_s = req_s & ~accept_s & (stall_q == STALL_W'(TIMEOUT));
        if (req_s & ~accept_s & ~force_s) begin
            stall_d = stall_q + STALL_W'(1);
        end else begin
            stall_d = STALL_W'(0);
        end
        if (force_s) begin
            to_seen_d = 1'b1;
        end else if (stat_rd_s) begin
            to_seen_d = 1'b0;
        end else begin
            to_seen_d = to_seen_q;
        end
    end

    // Stall counter and timeout flag registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            stall_q   <= STALL_W'(0);
            to_seen_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            to_seen_q <= to_seen_d;
        end
    end

    assign to_bit_s = to_seen_q;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT);
    assign force_s  = 1'b0;
    assign to_bit_s = 1'b0;
`endif

    // Registered Wishbone response; data is held at zero outside ack.
    always_comb begin
        ack_d = accept_s | force_s;
        if (force_s) begin
            if (wbs_we_i) begin
                dat_d = 32'h0000_0000;
            end else begin
                dat_d = 32'hDEAD_BEEF;
            end
        end else if (accept_s) begin
            dat_d = rdata_s;
        end else begin
            dat_d = 32'h0000_0000;
        end
    end

    // Next-state for both FIFOs, frame counter and sticky flags.
    always_comb begin
        x_wr_d = x_push_s ? (x_wr_q + PTR_W'(1)) : x_wr_q;
        x_rd_d = x_pop_s  ? (x_rd_q + PTR_W'(1)) : x_rd_q;
        case ({x_push_s, x_pop_s})
            2'b10:   x_level_d = x_level_q + LVL_W'(1);
            2'b01:   x_level_d = x_level_q - LVL_W'(1);
            default: x_level_d = x_level_q;
        endcase

        y_wr_d = y_push_s ? (y_wr_q + PTR_W'(1)) : y_wr_q;
        y_rd_d = y_pop_s  ? (y_rd_q + PTR_W'(1)) : y_rd_q;
        case ({y_push_s, y_pop_s})
            2'b10:   y_level_d = y_level_q + LVL_W'(1);
            2'b01:   y_level_d = y_level_q - LVL_W'(1);
            default: y_level_d = y_level_q;
        endcase

        if (len_wr_s) begin
            len_d = wbs_dat_i[LEN_W-1:0];
        end else begin
            len_d = len_q;
        end

        // A length write restarts the frame even if a beat leaves this cycle.
        if (len_wr_s) begin
            cnt_d = LEN_W'(0);
        end else if (x_pop_s) begin
            if (last_hit_s) begin
                cnt_d = LEN_W'(0);
            end else begin
                cnt_d = cnt_inc_s[LEN_W-1:0];
            end
        end else begin
            cnt_d = cnt_q;
        end

        // Setting wins over the status-read clear, so a tlast arriving in the
        // same cycle as the read is not lost.
        if (y_push_s & sm_tlast) begin
            y_last_d = 1'b1;
        end else if (stat_rd_s) begin
            y_last_d = 1'b0;
        end else begin
            y_last_d = y_last_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0000_0000;
            x_wr_q    <= PTR_W'(0);
            x_rd_q    <= PTR_W'(0);
            x_level_q <= LVL_W'(0);
            y_wr_q    <= PTR_W'(0);
            y_rd_q    <= PTR_W'(0);
            y_level_q <= LVL_W'(0);
            len_q     <= LEN_RST;
            cnt_q     <= LEN_W'(0);
            y_last_q  <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            x_wr_q    <= x_wr_d;
            x_rd_q    <= x_rd_d;
            x_level_q <= x_level_d;
            y_wr_q    <= y_wr_d;
            y_rd_q    <= y_rd_d;
            y_level_q <= y_level_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            y_last_q  <= y_last_d;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge wb_clk_i) begin
        if (x_push_s) begin
            x_mem_q[x_wr_q] <= pDATA_WIDTH'(wbs_dat_i);
        end
        if (y_push_s) begin
            y_mem_q[y_wr_q] <= sm_tdata;
        end
    end

endmodule
